reset_seq_ctrl: RTL and testbench

- Reset source and sequencer for a group of reset domains; drives the active-low domain resets that the portable reset cells buffer, mux and gate downstream.
- Asserts all domain resets asynchronously on `rn` and releases them synchronously, one domain at a time, in a fixed order.
- Also runs a software warm reset: a quiesce handshake with the domains, a synchronous assert/hold, then the same staged release.

---
 rtl/reset_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_reset_seq_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: async assert, synchronous staged release of NUM_DOMAINS active-low resets,
// plus a software warm reset with a quiesce handshake, synchronous hold and the same release.
module reset_seq_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_DOMAINS = 3,
  parameter int unsigned STAGE_DLY   = 4,
  parameter int unsigned HOLD_CYC    = 8,
  parameter int unsigned QTIMEOUT    = 16
) (
  input  logic                   ck,
  input  logic                   rn,
  input  logic                   sw_rst_req,
  input  logic                   quiesce_ack,
  output logic [NUM_DOMAINS-1:0] rst_n_out,
  output logic                   quiesce_req,
  output logic                   sw_rst_ack,
  output logic                   quiesce_timeout,
  output logic                   seq_done
);

  localparam int unsigned MaxSh  = (STAGE_DLY > HOLD_CYC) ? STAGE_DLY : HOLD_CYC;
  localparam int unsigned MaxCnt = (MaxSh > QTIMEOUT) ? MaxSh : QTIMEOUT;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam int unsigned IdxW   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  // Terminal values are one less: the count reaches its target on the edge that acts on it.
  localparam logic [CntW-1:0] StageLast = CntW'(STAGE_DLY - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(HOLD_CYC - 1);
  localparam logic [CntW-1:0] QLast     = CntW'(QTIMEOUT - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    StSync,
    StRelease,
    StRun,
    StQuiesce,
    StAssert
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q;
  logic [IdxW-1:0]        idx_q;
  logic [NUM_DOMAINS-1:0] rst_n_q;
  logic                   quiesce_req_q;
  logic                   sw_rst_ack_q;
  logic                   quiesce_timeout_q;
  logic                   seq_done_q;
  logic [NUM_DOMAINS-1:0] release_mask;
  logic                   rn_sync;
  logic                   sync_rise;

  always_ff @(posedge ck or negedge rn) begin
    if (!rn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rn_sync = sync_q[SYNC_STAGES-1];
  // Leave SYNC on the edge that loads the last synchronizer stage with 1.
  assign sync_rise = sync_q[SYNC_STAGES-2];

  always_comb begin
    release_mask = '0;
    for (int i = 0; i < int'(NUM_DOMAINS); i++) begin
      if (idx_q == IdxW'(i)) release_mask[i] = 1'b1;
    end
  end

  always_ff @(posedge ck or negedge rn) begin
    if (!rn) begin
      state_q           <= StSync;
      cnt_q             <= '0;
      idx_q             <= '0;
      rst_n_q           <= '0;
      quiesce_req_q     <= 1'b0;
      sw_rst_ack_q      <= 1'b0;
      quiesce_timeout_q <= 1'b0;
      seq_done_q        <= 1'b0;
    end else begin
      sw_rst_ack_q <= 1'b0;
      unique case (state_q)
        StSync: begin
          if (sync_rise || rn_sync) begin
            state_q <= StRelease;
            cnt_q   <= '0;
            idx_q   <= '0;
          end
        end
        StRelease: begin
          if (cnt_q == StageLast) begin
            rst_n_q <= rst_n_q | release_mask;
            cnt_q   <= '0;
            idx_q   <= idx_q + 1'b1;
            if (idx_q == IdxLast) begin
              state_q    <= StRun;
              seq_done_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (sw_rst_req) begin
            state_q           <= StQuiesce;
            quiesce_req_q     <= 1'b1;
            quiesce_timeout_q <= 1'b0;
            cnt_q             <= '0;
          end
        end
        StQuiesce: begin
          if (quiesce_ack || (cnt_q == QLast)) begin
            state_q           <= StAssert;
            quiesce_req_q     <= 1'b0;
            seq_done_q        <= 1'b0;
            rst_n_q           <= '0;
            cnt_q             <= '0;
            // A late ack on the timeout edge still counts as a clean drain.
            quiesce_timeout_q <= ~quiesce_ack;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StAssert: begin
          if (cnt_q == HoldLast) begin
            sw_rst_ack_q <= 1'b1;
            state_q      <= StRelease;
            cnt_q        <= '0;
            idx_q        <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StSync;
      endcase
    end
  end

  assign rst_n_out       = rst_n_q;
  assign quiesce_req     = quiesce_req_q;
  assign sw_rst_ack      = sw_rst_ack_q;
  assign quiesce_timeout = quiesce_timeout_q;
  assign seq_done        = seq_done_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed, table-driven bench for reset_seq_ctrl at default parameters.
module tb_reset_seq_ctrl;

  logic       ck = 1'b0;
  logic       rn = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic       quiesce_ack = 1'b0;
  logic [2:0] rst_n_out;
  logic       quiesce_req;
  logic       sw_rst_ack;
  logic       quiesce_timeout;
  logic       seq_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned cycles;
    logic        rn;
    logic        req;
    logic        ack;
    logic [2:0]  rst;
    logic        qreq;
    logic        sack;
    logic        qto;
    logic        done;
  } vec_t;

  vec_t tbl[$];

  reset_seq_ctrl dut (
    .ck              (ck),
    .rn              (rn),
    .sw_rst_req      (sw_rst_req),
    .quiesce_ack     (quiesce_ack),
    .rst_n_out       (rst_n_out),
    .quiesce_req     (quiesce_req),
    .sw_rst_ack      (sw_rst_ack),
    .quiesce_timeout (quiesce_timeout),
    .seq_done        (seq_done)
  );

  always #5 ck = ~ck;

  function automatic void add(int unsigned n, logic r, logic q, logic a, logic [2:0] rst,
                              logic qr, logic sk, logic to, logic dn);
    vec_t v;
    v = '{cycles: n, rn: r, req: q, ack: a, rst: rst, qreq: qr, sack: sk, qto: to, done: dn};
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {rst_n_out, quiesce_req, sw_rst_ack, quiesce_timeout, seq_done};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {rst,qreq,sack,qto,done}=%b, expected %b at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic run_row(input int idx, input vec_t v);
    for (int c = 0; c < int'(v.cycles); c++) begin
      @(negedge ck);
      rn          = v.rn;
      sw_rst_req  = v.req;
      quiesce_ack = v.ack;
      @(posedge ck);
      #1;
      check($sformatf("row%0d.cyc%0d", idx, c), {v.rst, v.qreq, v.sack, v.qto, v.done});
    end
  endtask

  initial begin
    // n  rn req ack  rst   qreq sack qto done
    // Cold boot: edge 1 is the first edge with rn high.
    add(3, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    add(5, 1, 0, 0, 3'b000, 0, 0, 0, 0);
    add(4, 1, 0, 0, 3'b001, 0, 0, 0, 0);
    add(4, 1, 0, 0, 3'b011, 0, 0, 0, 0);
    add(3, 1, 0, 0, 3'b111, 0, 0, 0, 1);
    // Warm reset, ack three cycles after the request edge.
    add(1, 1, 1, 0, 3'b111, 1, 0, 0, 1);
    add(2, 1, 0, 0, 3'b111, 1, 0, 0, 1);
    add(1, 1, 0, 1, 3'b000, 0, 0, 0, 0);
    add(7, 1, 0, 0, 3'b000, 0, 0, 0, 0);
    add(1, 1, 0, 0, 3'b000, 0, 1, 0, 0);
    add(3, 1, 0, 0, 3'b000, 0, 0, 0, 0);
    add(4, 1, 0, 0, 3'b001, 0, 0, 0, 0);
    add(4, 1, 0, 0, 3'b011, 0, 0, 0, 0);
    add(1, 1, 0, 0, 3'b111, 0, 0, 0, 1);
    // Warm reset, no ack: 16 cycles of quiesce_req, then sticky timeout.
    add(1, 1, 1, 0, 3'b111, 1, 0, 0, 1);
    add(15, 1, 0, 0, 3'b111, 1, 0, 0, 1);
    add(1, 1, 0, 0, 3'b000, 0, 0, 1, 0);
    add(7, 1, 0, 0, 3'b000, 0, 0, 1, 0);
    add(1, 1, 0, 0, 3'b000, 0, 1, 1, 0);
    add(3, 1, 0, 0, 3'b000, 0, 0, 1, 0);
    add(4, 1, 0, 0, 3'b001, 0, 0, 1, 0);
    add(4, 1, 0, 0, 3'b011, 0, 0, 1, 0);
    add(2, 1, 0, 0, 3'b111, 0, 0, 1, 1);
    // Ack on the 16th quiesce edge beats the timeout; accepting the request clears the flag.
    add(1, 1, 1, 0, 3'b111, 1, 0, 0, 1);
    add(15, 1, 0, 0, 3'b111, 1, 0, 0, 1);
    add(1, 1, 0, 1, 3'b000, 0, 0, 0, 0);
    // Request held through ASSERT/RELEASE, stray acks: retriggers only once back in RUN.
    add(7, 1, 1, 0, 3'b000, 0, 0, 0, 0);
    add(1, 1, 1, 0, 3'b000, 0, 1, 0, 0);
    add(3, 1, 1, 1, 3'b000, 0, 0, 0, 0);
    add(4, 1, 1, 1, 3'b001, 0, 0, 0, 0);
    add(4, 1, 1, 1, 3'b011, 0, 0, 0, 0);
    add(1, 1, 1, 1, 3'b111, 0, 0, 0, 1);
    add(1, 1, 1, 1, 3'b111, 1, 0, 0, 1);
    add(1, 1, 0, 1, 3'b000, 0, 0, 0, 0);
    add(7, 1, 0, 0, 3'b000, 0, 0, 0, 0);
    add(1, 1, 0, 0, 3'b000, 0, 1, 0, 0);
    add(3, 1, 0, 0, 3'b000, 0, 0, 0, 0);
    add(4, 1, 0, 0, 3'b001, 0, 0, 0, 0);

    #1 rn = 1'b0;
    for (int i = 0; i < tbl.size(); i++) run_row(i, tbl[i]);

    // Mid-release master reset: outputs clear with no clock edge.
    #2 rn = 1'b0;
    #1 check("async_clear", 7'b000_0_0_0_0);
    // Cold sequence repeats with identical timing.
    for (int i = 0; i < 5; i++) run_row(100 + i, tbl[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
